// File: rtl/handshake_slave.sv
// handshake_slave: valid/ready receiver with a 2-entry FIFO drained by a valid/pop consumer.
// Define HS_SLAVE_CNT_EN to add the 16-bit xfer_cnt push counter output.
module handshake_slave #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] data_out,
    input  logic              rd_en,
    output logic              overflow_err
`ifdef HS_SLAVE_CNT_EN
    ,
    output logic [15:0]       xfer_cnt
);
`else
);
`endif

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] entry1, data_q;
    logic              push, pop, load0, load1, shift, stall_q, stall_bad;

    // data_out is entry0 itself, so the head word is always a flop output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= EMPTY;
            ready        <= 1'b0;
            data_out     <= '0;
            entry1       <= '0;
            stall_q      <= 1'b0;
            data_q       <= '0;
            overflow_err <= 1'b0;
        end else begin
            state        <= state_next;
            ready        <= state_next != FULL;
            data_out     <= load0 ? data_in : shift ? entry1 : data_out;
            entry1       <= load1 ? data_in : entry1;
            stall_q      <= valid & ~ready;
            data_q       <= data_in;
            overflow_err <= overflow_err | stall_bad;
        end
    end

    always_comb begin
        state_next = state == EMPTY ? (push ? ONE : EMPTY) :
                     state == ONE   ? (push & ~pop ? FULL : pop & ~push ? EMPTY : ONE) :
                     state == FULL  ? (pop ? ONE : FULL) : EMPTY;
    end

    always_comb begin
        out_valid = state != EMPTY;
        push      = valid & ready;
        pop       = rd_en & out_valid;
        load0     = push & (state == EMPTY | pop);
        load1     = push & ~pop & state == ONE;
        shift     = pop & state == FULL;
        // a stalled master must keep valid high and data_in stable until accepted
        stall_bad = stall_q & ~ready & (~valid | data_in != data_q);
    end

`ifdef HS_SLAVE_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            xfer_cnt <= '0;
        else if (push)
            xfer_cnt <= xfer_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_handshake_slave.sv
// tb_handshake_slave: vector table, corner sequences and randomized traffic checked against a queue model.
module tb_handshake_slave;

    logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, rd_en = 1'b0;
    logic [31:0] data_in = '0;
    logic        ready, out_valid, overflow_err;
    logic [31:0] data_out;
`ifdef HS_SLAVE_CNT_EN
    logic [15:0] xfer_cnt;
`endif

    always #5 clk = ~clk;

    handshake_slave #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .data_in(data_in),
        .ready(ready), .out_valid(out_valid), .data_out(data_out),
        .rd_en(rd_en), .overflow_err(overflow_err)
`ifdef HS_SLAVE_CNT_EN
        , .xfer_cnt(xfer_cnt)
`endif
    );

    int n_checks = 0, n_fail = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: FIFO of accepted words with capacity 2
    logic [31:0] mq[$];
    logic        m_ready = 1'b0, m_err = 1'b0, m_ps = 1'b0, m_push, m_pop;
    logic [31:0] m_pd = '0, m_head = '0;
    logic [15:0] m_cnt = '0;

    task automatic model_step();
        if (!rst_n) begin
            mq.delete();
            m_ready = 1'b0; m_err = 1'b0; m_ps = 1'b0;
            m_pd = '0; m_head = '0; m_cnt = '0;
        end else begin
            m_push = valid && m_ready;
            m_pop  = rd_en && mq.size() != 0;
            if (m_ps && !m_ready && (!valid || data_in != m_pd)) m_err = 1'b1;
            m_ps = valid && !m_ready;
            m_pd = data_in;
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back(data_in);
                m_cnt = m_cnt + 16'd1;
            end
            m_ready = mq.size() < 2;
            if (mq.size() != 0) m_head = mq[0];
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_ready", ready, m_ready);
            chk("mon_out_valid", out_valid, mq.size() != 0);
            chk("mon_data_out", data_out, m_head);
            chk("mon_overflow_err", overflow_err, m_err);
`ifdef HS_SLAVE_CNT_EN
            chk("mon_xfer_cnt", xfer_cnt, m_cnt);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst_n, valid, rd_en;
        logic [31:0] data;
        logic        e_ready, e_ov;
        logic [31:0] e_do;
        logic        e_err;
    } vec_t;

    vec_t vt[11];

    initial begin
        vt[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 32'hA5A5_0001, 1'b1, 1'b1, 32'hA5A5_0001, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hA5A5_0001, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 32'h2,         1'b0, 1'b1, 32'hA5A5_0001, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 32'h3,         1'b0, 1'b1, 32'hA5A5_0001, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 1'b1, 32'h3,         1'b1, 1'b1, 32'h2,         1'b0};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 32'h3,         1'b0, 1'b1, 32'h2,         1'b0};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'h3,         1'b0};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 32'h3,         1'b0};
        vt[10] = '{1'b1, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 32'h3,         1'b0};

        repeat (3) tick();
        mon_en = 1'b1;

        for (int i = 0; i < 11; i++) begin
            rst_n = vt[i].rst_n; valid = vt[i].valid; rd_en = vt[i].rd_en; data_in = vt[i].data;
            tick();
            chk($sformatf("vec%0d_ready", i), ready, vt[i].e_ready);
            chk($sformatf("vec%0d_out_valid", i), out_valid, vt[i].e_ov);
            chk($sformatf("vec%0d_data_out", i), data_out, vt[i].e_do);
            chk($sformatf("vec%0d_overflow_err", i), overflow_err, vt[i].e_err);
        end

        // reset while FULL flushes both entries
        rd_en = 1'b0; valid = 1'b1; data_in = 32'd7; tick();
        data_in = 32'd8; tick();
        chk("full_before_reset_ready", ready, 1'b0);
        valid = 1'b0; rst_n = 1'b0; tick();
        chk("rst_full_out_valid", out_valid, 1'b0);
        chk("rst_full_ready", ready, 1'b0);
        chk("rst_full_data_out", data_out, 32'h0);
        rst_n = 1'b1; tick();
        valid = 1'b1; data_in = 32'd9; tick();
        valid = 1'b0; tick();
        chk("after_rst_out_valid", out_valid, 1'b1);
        chk("after_rst_first_word", data_out, 32'd9);
        rd_en = 1'b1; tick();
        rd_en = 1'b0;

        // data change while stalled sets the sticky error
        valid = 1'b1; data_in = 32'h1; tick();
        data_in = 32'h2; tick();
        data_in = 32'h11; tick();
        chk("stall_hold_err", overflow_err, 1'b0);
        data_in = 32'h22; tick();
        chk("stall_change_err", overflow_err, 1'b1);
        valid = 1'b0; rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("err_sticky", overflow_err, 1'b1);
        end
        rd_en = 1'b0; rst_n = 1'b0; tick();
        chk("err_cleared_by_reset", overflow_err, 1'b0);
        rst_n = 1'b1; tick();

        // full throughput: push and pop every cycle
        rd_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            valid = 1'b1; data_in = 32'd100 + 32'(i);
            tick();
            chk("thru_ready", ready, 1'b1);
            chk("thru_out_valid", out_valid, 1'b1);
            chk("thru_data_out", data_out, 32'd100 + 32'(i));
        end
        valid = 1'b0; tick();
        chk("thru_drained", out_valid, 1'b0);
        chk("thru_no_err", overflow_err, 1'b0);

        // randomized protocol-compliant traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst_n = $urandom_range(0, 299) != 0;
            if (!(valid && !m_ready)) begin
                valid   = $urandom_range(0, 1) == 1;
                data_in = $urandom();
            end
            rd_en = $urandom_range(0, 2) != 0;
            tick();
        end
        rst_n = 1'b1; valid = 1'b0; rd_en = 1'b0; tick();

`ifdef HS_SLAVE_CNT_EN
        rst_n = 1'b0; tick();
        rst_n = 1'b1; tick();
        rd_en = 1'b1; valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            data_in = 32'(i);
            tick();
        end
        chk("cnt_preload", xfer_cnt, 16'hFFFF);
        data_in = 32'hFFFF; tick();
        chk("cnt_wrap", xfer_cnt, 16'h0000);
        valid = 1'b0; tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/handshake_slave.md
Name: handshake_slave

Overview:
Receiving end of the valid/ready handshake driven by handshake_master. It accepts words from the master when valid and ready are both high, and holds them in a 2-entry buffer. A local consumer drains the buffer through a simple valid/pop interface. The buffer absorbs one cycle of consumer stall without dropping ready, so back-to-back master transfers sustain full throughput while the consumer pops every cycle.

Parameters:
DATA_W, 32, width of the handshake data bus and of each buffer entry.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst_n  input  1  reset, synchronous, active-low.
valid  input  1  master has a word on data_in.
data_in  input  DATA_W  word from the master; sampled only on handshake.
ready  output  1  slave can accept a word this cycle; registered.
out_valid  output  1  buffer head holds a valid word.
data_out  output  DATA_W  buffer head word.
rd_en  input  1  consumer pop request; effective only when out_valid=1.
overflow_err  output  1  sticky flag: master changed data_in or dropped valid while stalled (valid=1, ready=0).

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - state=EMPTY, ready=0, out_valid=0, data_out=0, both entries=0, overflow_err=0.
  - Reset mid-operation flushes all buffered words with no drain.
- ready is a register.
  - It is 0 in the first cycle after reset release, then 1 from the next edge onward (while the state is not FULL).
  - ready_next = (next_state != FULL).
  - No combinational path from valid or rd_en to ready.
- Events:
  - push = valid & ready.
  - pop = rd_en & out_valid. rd_en while out_valid=0 is ignored, with no state change.
- States (occupancy):
  - EMPTY: push -> ONE (entry0=data_in). No pop is possible.
  - ONE:
    - push & !pop -> FULL (entry1=data_in).
    - pop & !push -> EMPTY.
    - push & pop -> ONE (entry0=data_in).
    - Neither -> ONE.
  - FULL: ready=0, so no push.
    - pop -> ONE (entry0<=entry1).
    - No pop -> FULL.
- Output timing:
  - out_valid=(state != EMPTY).
  - data_out=entry0, registered. The write path and the shift-on-pop both update entry0.
  - Latency: a word handshaken at edge N is on data_out with out_valid=1 in the cycle after edge N. There is no same-cycle bypass.
- Ordering: strict FIFO, no duplication, no loss.
- Stall check: the slave registers the previous cycle's stall (valid=1 & ready=0) and data_in. overflow_err sets if, in the next cycle, either of the following occurs:
  - valid=0 while still ready=0, or
  - data_in differs while valid=1 & ready=0.
  overflow_err clears only on reset.
- Compatibility with handshake_master: the master deasserts valid the cycle after a handshake. A new en can reassert it the following cycle. The slave must accept such a pattern with no error.

Optional Feature:
HS_SLAVE_CNT_EN:
- Defined: adds output port xfer_cnt (16 bits).
  - Counts accepted pushes, +1 per push edge.
  - Wraps 16'hFFFF -> 16'h0000.
  - Reset value 0.
  - Pops do not affect it.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, valid=0: ready=0 for cycle 1 after release, then 1; out_valid=0, data_out=0, overflow_err=0.
- Single word 32'hA5A5_0001 with rd_en=0: handshake at edge N; out_valid=1 and data_out=A5A5_0001 after N; state ONE, ready stays 1.
- Words 1,2,3 offered back-to-back with rd_en=0: 1 and 2 accepted; ready=0 after the second push; 3 held until a pop, then accepted. Pops yield 1,2,3 in order; xfer_cnt=3 if HS_SLAVE_CNT_EN is defined.
- Continuous valid with incrementing data plus rd_en=1 every cycle for 100 words: ready never drops after the first push; all 100 words out in order; overflow_err=0.
- Reset asserted while FULL (entries 7,8): after the reset edge, out_valid=0, ready=0, data_out=0. After release, the next pushed word 9 is the first out.
- While ready=0, the master changes data_in from 32'h11 to 32'h22 with valid=1: overflow_err=1 from the following cycle, and it stays 1 until reset.
- With HS_SLAVE_CNT_EN defined, preload 65535 pushes, then one more: xfer_cnt=0.
